alu_result_stage: RTL and testbench

//  Execute->writeback stage directly downstream of the 16-bit ALU. Captures Result plus the

---
 rtl/cpu16_pkg.sv | 18 +
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/stage_fifo.sv | 61 ++++++
 rtl/alu_result_stage.sv | 73 +++++++
 tb/tb_alu_result_stage.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu16_pkg.sv
// Shared CPU16 datapath constants, status-flag bit positions and the writeback entry type.
package cpu16_pkg;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] addr;
    logic              wren;
  } wb_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-side and register-file-side handshake bundle of the ALU result stage.
// master = ALU / register file environment, slave = the result stage itself.
interface alu_result_stage_if;
  import cpu16_pkg::*;

  logic              InValid;
  logic              InReady;
  logic [WIDTH-1:0]  Result;
  logic              Zero;
  logic              Overflow;
  logic              CarryOut;
  logic [ADDR_W-1:0] RdAddr;
  logic              RegWrEn;
  logic              FlagWrEn;
  logic              OutValid;
  logic              OutReady;
  logic [WIDTH-1:0]  WbData;
  logic [ADDR_W-1:0] WbAddr;
  logic              WbEn;
  logic [3:0]        Flags;
  logic              FwdValid;
  logic [ADDR_W-1:0] FwdAddr;
  logic [WIDTH-1:0]  FwdData;

  modport master (
    output InValid, Result, Zero, Overflow, CarryOut, RdAddr, RegWrEn, FlagWrEn, OutReady,
    input  InReady, OutValid, WbData, WbAddr, WbEn, Flags, FwdValid, FwdAddr, FwdData
  );

  modport slave (
    input  InValid, Result, Zero, Overflow, CarryOut, RdAddr, RegWrEn, FlagWrEn, OutReady,
    output InReady, OutValid, WbData, WbAddr, WbEn, Flags, FwdValid, FwdAddr, FwdData
  );

endinterface

// File: rtl/stage_fifo.sv
// Generic DEPTH-entry synchronous FIFO of writeback entries; head is read combinationally
// from storage, so there is no empty bypass and an accepted entry appears one cycle later.
module stage_fifo
  import cpu16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output wb_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute->writeback stage: buffers ALU results for the register file and keeps the {N,Z,C,V}
// status register. Define ALU_RESULT_FWD_EN to drive the head entry onto the forwarding port.
module alu_result_stage
  import cpu16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  alu_result_stage_if.slave bus
);

  wb_entry_t  in_entry;
  wb_entry_t  head_entry;
  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic [3:0] flags_q, flags_d;

  assign in_entry.data = bus.Result;
  assign in_entry.addr = bus.RdAddr;
  assign in_entry.wren = bus.RegWrEn;

  // InReady comes only from the registered count, never from OutReady.
  assign bus.InReady  = ~fifo_full;
  assign bus.OutValid = ~fifo_empty;
  assign push         = bus.InValid & ~fifo_full;
  assign pop          = bus.OutReady & ~fifo_empty;

  stage_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_entry),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.WbData = head_entry.data;
  assign bus.WbAddr = head_entry.addr;
  assign bus.WbEn   = head_entry.wren;

  always_comb begin
    flags_d = flags_q;
    if (push && bus.FlagWrEn) begin
      flags_d[FLAG_N] = bus.Result[WIDTH-1];
      flags_d[FLAG_Z] = bus.Zero;
      flags_d[FLAG_C] = bus.CarryOut;
      flags_d[FLAG_V] = bus.Overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign bus.Flags = flags_q;

`ifdef ALU_RESULT_FWD_EN
  assign bus.FwdValid = ~fifo_empty & head_entry.wren;
  assign bus.FwdAddr  = head_entry.addr;
  assign bus.FwdData  = head_entry.data;
`else
  assign bus.FwdValid = 1'b0;
  assign bus.FwdAddr  = '0;
  assign bus.FwdData  = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (DEPTH=2), with or without ALU_RESULT_FWD_EN.
module tb_alu_result_stage;
  import cpu16_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  alu_result_stage_if bus ();

  alu_result_stage #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ALU side must hold a stalled op: InValid stays high and payload is frozen.
  logic        prev_stall;
  logic [26:0] prev_payload;
  initial prev_stall = 1'b0;
  always @(posedge clk) begin
    if (prev_stall && !reset) begin
      tests_run++;
      if (bus.InValid !== 1'b1 ||
          {bus.Result, bus.Zero, bus.Overflow, bus.CarryOut, bus.RdAddr, bus.RegWrEn, bus.FlagWrEn} !== prev_payload) begin
        tests_failed++;
        $display("FAIL hold_stalled_op: InValid=%b payload=%h required InValid=1 payload=%h",
                 bus.InValid,
                 {bus.Result, bus.Zero, bus.Overflow, bus.CarryOut, bus.RdAddr, bus.RegWrEn, bus.FlagWrEn},
                 prev_payload);
      end
    end
    prev_stall   = bus.InValid & ~bus.InReady & ~reset;
    prev_payload = {bus.Result, bus.Zero, bus.Overflow, bus.CarryOut, bus.RdAddr, bus.RegWrEn, bus.FlagWrEn};
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [15:0] res, input logic z, input logic v, input logic c,
                        input logic [2:0] rd, input logic rwe, input logic fwe);
    bus.InValid  = 1'b1;
    bus.Result   = res;
    bus.Zero     = z;
    bus.Overflow = v;
    bus.CarryOut = c;
    bus.RdAddr   = rd;
    bus.RegWrEn  = rwe;
    bus.FlagWrEn = fwe;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.InValid = 1'b0; bus.Result = '0; bus.Zero = 1'b0; bus.Overflow = 1'b0;
    bus.CarryOut = 1'b0; bus.RdAddr = '0; bus.RegWrEn = 1'b0; bus.FlagWrEn = 1'b0;
    bus.OutReady = 1'b0;
    step();
    step();
    reset = 1'b0;
    tests_run++;
    if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || bus.Flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: OutValid=%b InReady=%b Flags=%b required 0 1 0000",
               bus.OutValid, bus.InReady, bus.Flags);
    end
    tests_run++;
    if (bus.WbData !== 16'h0 || bus.WbAddr !== 3'd0 || bus.WbEn !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wb: WbData=%h WbAddr=%0d WbEn=%b required 0000 0 0",
               bus.WbData, bus.WbAddr, bus.WbEn);
    end
    tests_run++;
    if (bus.FwdValid !== 1'b0 || bus.FwdAddr !== 3'd0 || bus.FwdData !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_fwd: FwdValid=%b FwdAddr=%0d FwdData=%h required 0 0 0000",
               bus.FwdValid, bus.FwdAddr, bus.FwdData);
    end
  endtask

  task automatic test_single_op();
    bus.OutReady = 1'b1;
    set_op(16'h0000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
    step();
    bus.InValid = 1'b0;
    tests_run++;
    if (bus.OutValid !== 1'b1 || bus.WbData !== 16'h0000 || bus.WbAddr !== 3'd3 || bus.WbEn !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_wb: OutValid=%b WbData=%h WbAddr=%0d WbEn=%b required 1 0000 3 1",
               bus.OutValid, bus.WbData, bus.WbAddr, bus.WbEn);
    end
    tests_run++;
    if (bus.Flags !== 4'b0110) begin
      tests_failed++;
      $display("FAIL single_flags: Flags=%b required 0110", bus.Flags);
    end
    step();
    tests_run++;
    if (bus.OutValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drained: OutValid=%b required 0", bus.OutValid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got [8];
    int          n;
    logic        accepted;
    n = 0;
    bus.OutReady = 1'b0;
    set_op(16'h0001, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    tests_run++;
    if (bus.InReady !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_empty: InReady=%b required 1", bus.InReady);
    end
    step();
    set_op(16'h0002, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    step();
    set_op(16'h0003, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    tests_run++;
    if (bus.InReady !== 1'b0 || bus.OutValid !== 1'b1 || bus.WbData !== 16'h0001) begin
      tests_failed++;
      $display("FAIL bp_full: InReady=%b OutValid=%b WbData=%h required 0 1 0001",
               bus.InReady, bus.OutValid, bus.WbData);
    end
    step();
    tests_run++;
    if (bus.InReady !== 1'b0 || bus.WbData !== 16'h0001) begin
      tests_failed++;
      $display("FAIL bp_held: InReady=%b WbData=%h required 0 0001", bus.InReady, bus.WbData);
    end
    bus.OutReady = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (bus.OutValid === 1'b1) begin
        if (n < 8) got[n] = bus.WbData;
        n++;
      end
      accepted = bus.InValid & bus.InReady;
      step();
      if (accepted) bus.InValid = 1'b0;
    end
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL bp_pop_count: got %0d pops required 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= n || got[k] !== 16'(k + 1)) begin
        tests_failed++;
        $display("FAIL bp_order[%0d]: got %h required %h", k, (k < n) ? got[k] : 16'hxxxx, 16'(k + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.OutReady = 1'b0;
    set_op(16'h0100, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    step();
    bus.OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_op(16'h0101 + 16'(i), 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
      tests_run++;
      if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_count1[%0d]: OutValid=%b InReady=%b required 1 1", i, bus.OutValid, bus.InReady);
      end
      tests_run++;
      if (bus.WbData !== 16'h0100 + 16'(i)) begin
        tests_failed++;
        $display("FAIL b2b_data[%0d]: WbData=%h required %h", i, bus.WbData, 16'h0100 + 16'(i));
      end
      step();
    end
    bus.InValid = 1'b0;
    tests_run++;
    if (bus.OutValid !== 1'b1 || bus.WbData !== 16'h010A) begin
      tests_failed++;
      $display("FAIL b2b_last: OutValid=%b WbData=%h required 1 010a", bus.OutValid, bus.WbData);
    end
    step();
    tests_run++;
    if (bus.OutValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drained: OutValid=%b required 0", bus.OutValid);
    end
  endtask

  task automatic test_flags();
    bus.OutReady = 1'b1;
    set_op(16'h8000, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
    step();
    tests_run++;
    if (bus.Flags !== 4'b1001) begin
      tests_failed++;
      $display("FAIL flags_overflow: Flags=%b required 1001", bus.Flags);
    end
    set_op(16'h0000, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
    step();
    bus.InValid = 1'b0;
    tests_run++;
    if (bus.Flags !== 4'b1001) begin
      tests_failed++;
      $display("FAIL flags_hold: Flags=%b required 1001", bus.Flags);
    end
    tests_run++;
    if (bus.OutValid !== 1'b1 || bus.WbEn !== 1'b0 || bus.WbAddr !== 3'd6) begin
      tests_failed++;
      $display("FAIL bubble_head: OutValid=%b WbEn=%b WbAddr=%0d required 1 0 6",
               bus.OutValid, bus.WbEn, bus.WbAddr);
    end
    step();
    tests_run++;
    if (bus.OutValid !== 1'b0 || bus.Flags !== 4'b1001) begin
      tests_failed++;
      $display("FAIL bubble_popped: OutValid=%b Flags=%b required 0 1001", bus.OutValid, bus.Flags);
    end
  endtask

  task automatic test_mid_reset();
    bus.OutReady = 1'b0;
    set_op(16'h0005, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1);
    step();
    set_op(16'h0006, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    step();
    bus.InValid = 1'b0;
    tests_run++;
    if (bus.InReady !== 1'b0 || bus.Flags !== 4'b0010) begin
      tests_failed++;
      $display("FAIL mreset_pre: InReady=%b Flags=%b required 0 0010", bus.InReady, bus.Flags);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || bus.Flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mreset_post: OutValid=%b InReady=%b Flags=%b required 0 1 0000",
               bus.OutValid, bus.InReady, bus.Flags);
    end
    bus.OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (bus.OutValid !== 1'b0) begin
        tests_failed++;
        $display("FAIL mreset_stale[%0d]: OutValid=%b required 0", i, bus.OutValid);
      end
    end
  endtask

  task automatic test_forwarding();
    logic            en;
    logic [2:0]      exp_addr;
    logic [15:0]     exp_data;
    logic [15:0]     exp_data2;
`ifdef ALU_RESULT_FWD_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    exp_addr  = en ? 3'd5 : 3'd0;
    exp_data  = en ? 16'h1234 : 16'h0000;
    exp_data2 = en ? 16'h5555 : 16'h0000;
    bus.OutReady = 1'b0;
    set_op(16'h1234, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0);
    step();
    set_op(16'h5555, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0);
    tests_run++;
    if (bus.FwdValid !== en || bus.FwdAddr !== exp_addr || bus.FwdData !== exp_data) begin
      tests_failed++;
      $display("FAIL fwd_head: FwdValid=%b FwdAddr=%0d FwdData=%h required %b %0d %h",
               bus.FwdValid, bus.FwdAddr, bus.FwdData, en, exp_addr, exp_data);
    end
    step();
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    step();
    tests_run++;
    if (bus.OutValid !== 1'b1 || bus.WbEn !== 1'b0 || bus.FwdValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_bubble: OutValid=%b WbEn=%b FwdValid=%b required 1 0 0",
               bus.OutValid, bus.WbEn, bus.FwdValid);
    end
    tests_run++;
    if (bus.FwdData !== exp_data2) begin
      tests_failed++;
      $display("FAIL fwd_bubble_data: FwdData=%h required %h", bus.FwdData, exp_data2);
    end
    step();
    tests_run++;
    if (bus.OutValid !== 1'b0 || bus.FwdValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_empty: OutValid=%b FwdValid=%b required 0 0", bus.OutValid, bus.FwdValid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_op();
    test_backpressure();
    test_back_to_back();
    test_flags();
    test_mid_reset();
    test_forwarding();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
